// File: rtl/jedro_1_lsu_pkg.sv
// rtl/jedro_1_lsu_pkg.sv - shared definitions for the jedro_1 load-store unit
package jedro_1_lsu_pkg;

   localparam int LSU_DATA_WIDTH     = 32;
   localparam int LSU_REG_ADDR_WIDTH = 5;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'b00,
      LSU_REQ  = 2'b01,
      LSU_WAIT = 2'b10
   } lsu_state_e;

   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == LSU_SIZE_H) && off[0]) || ((size == LSU_SIZE_W) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/jedro_1_lsu_load_align.sv
// rtl/jedro_1_lsu_load_align.sv - shifts the addressed lanes of a read word down and extends them
module jedro_1_lsu_load_align
   import jedro_1_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] result
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {off, 3'b000};
      case (size)
         LSU_SIZE_B: result = {{24{~uns & shifted[7]}}, shifted[7:0]};
         LSU_SIZE_H: result = {{16{~uns & shifted[15]}}, shifted[15:0]};
         default:    result = shifted;
      endcase
   end

endmodule

// File: rtl/jedro_1_lsu.sv
// rtl/jedro_1_lsu.sv - jedro_1 load-store unit: one command at a time over a req/gnt/rvalid bus
module jedro_1_lsu
   import jedro_1_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = LSU_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = LSU_REG_ADDR_WIDTH
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_we_i,
   input  logic [1:0]                cmd_size_i,
   input  logic                      cmd_unsigned_i,
   input  logic [DATA_WIDTH-1:0]     cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
   input  logic [REG_ADDR_WIDTH-1:0] cmd_rd_i,
   output logic                      rd_we_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
   output logic [DATA_WIDTH-1:0]     rd_data_o,
   output logic                      done_o,
   output logic                      err_o,
   output logic                      misaligned_o,
   output logic                      data_req_o,
   input  logic                      data_gnt_i,
   input  logic                      data_rvalid_i,
   output logic                      data_we_o,
   output logic [3:0]                data_be_o,
   output logic [DATA_WIDTH-1:0]     data_addr_o,
   output logic [DATA_WIDTH-1:0]     data_wdata_o,
   input  logic [DATA_WIDTH-1:0]     data_rdata_i,
   input  logic                      data_err_i
);

   lsu_state_e state, next_state;

   logic [1:0]                off;
   logic [1:0]                lat_off;
   logic [1:0]                lat_size;
   logic                      lat_unsigned;
   logic [REG_ADDR_WIDTH-1:0] lat_rd;
   logic                      mis;
   logic [3:0]                be;
   logic [DATA_WIDTH-1:0]     lanes;
   logic [DATA_WIDTH-1:0]     load_data;

   assign off = cmd_addr_i[1:0];
   assign mis = lsu_misaligned(cmd_size_i, off);

   always_comb begin
      case (cmd_size_i)
         LSU_SIZE_B: begin
            be    = 4'b0001 << off;
            lanes = {4{cmd_wdata_i[7:0]}};
         end
         LSU_SIZE_H: begin
            be    = 4'b0011 << off;
            lanes = {2{cmd_wdata_i[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            lanes = cmd_wdata_i;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= LSU_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state  = state;
      cmd_ready_o = 1'b0;
      data_req_o  = 1'b0;
      case (state)
         LSU_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i && !mis) next_state = LSU_REQ;
         end
         LSU_REQ: begin
            data_req_o = 1'b1;
            if (data_gnt_i) next_state = LSU_WAIT;
         end
         LSU_WAIT: begin
            if (data_rvalid_i) next_state = LSU_IDLE;
         end
         default: next_state = LSU_IDLE;
      endcase
   end

   jedro_1_lsu_load_align u_load_align (
      .rdata  (data_rdata_i),
      .off    (lat_off),
      .size   (lat_size),
      .uns    (lat_unsigned),
      .result (load_data)
   );

   // Bus fields are captured at accept time so they stay stable through REQ regardless of upstream.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_we_o      <= 1'b0;
         rd_addr_o    <= '0;
         rd_data_o    <= '0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         misaligned_o <= 1'b0;
         data_we_o    <= 1'b0;
         data_be_o    <= 4'b0000;
         data_addr_o  <= '0;
         data_wdata_o <= '0;
         lat_off      <= 2'b00;
         lat_size     <= LSU_SIZE_B;
         lat_unsigned <= 1'b0;
         lat_rd       <= '0;
      end else begin
         rd_we_o      <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         misaligned_o <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (cmd_valid_i) begin
                  if (mis) begin
                     misaligned_o <= 1'b1;
                  end else begin
                     data_we_o    <= cmd_we_i;
                     data_be_o    <= be;
                     data_addr_o  <= {cmd_addr_i[DATA_WIDTH-1:2], 2'b00};
                     data_wdata_o <= lanes;
                     lat_off      <= off;
                     lat_size     <= cmd_size_i;
                     lat_unsigned <= cmd_unsigned_i;
                     lat_rd       <= cmd_rd_i;
                  end
               end
            end
            LSU_WAIT: begin
               if (data_rvalid_i) begin
                  done_o    <= 1'b1;
                  data_we_o <= 1'b0;
                  data_be_o <= 4'b0000;
                  if (data_err_i) begin
                     err_o <= 1'b1;
                  end else if (!data_we_o) begin
                     rd_we_o   <= (lat_rd != '0);
                     rd_addr_o <= lat_rd;
                     rd_data_o <= load_data;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jedro_1_lsu.sv
// tb/tb_jedro_1_lsu.sv - directed self-checking bench for jedro_1_lsu
module tb_jedro_1_lsu;
   import jedro_1_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, cmd_valid, cmd_ready, cmd_we, cmd_unsigned;
   logic [1:0]  cmd_size;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [4:0]  cmd_rd;
   logic        rd_we, done, err, misaligned;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        data_req, data_gnt, data_rvalid, data_we, data_err;
   logic [3:0]  data_be;
   logic [31:0] data_addr, data_wdata, data_rdata;

   always #5 clk = ~clk;

   jedro_1_lsu dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
      .cmd_size_i(cmd_size), .cmd_unsigned_i(cmd_unsigned), .cmd_addr_i(cmd_addr),
      .cmd_wdata_i(cmd_wdata), .cmd_rd_i(cmd_rd),
      .rd_we_o(rd_we), .rd_addr_o(rd_addr), .rd_data_o(rd_data),
      .done_o(done), .err_o(err), .misaligned_o(misaligned),
      .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
      .data_we_o(data_we), .data_be_o(data_be), .data_addr_o(data_addr),
      .data_wdata_o(data_wdata), .data_rdata_i(data_rdata), .data_err_i(data_err)
   );

   int n_vec = 0;
   int n_fail = 0;

   // expectations for the current cycle
   logic        chk_en = 1'b0;
   logic        e_ready, e_req, e_done, e_err, e_mis, e_rd_we;
   logic        e_bus_valid, e_bus_idle, e_rd_zero;
   logic [31:0] e_addr, e_wdata, e_rd_data;
   logic [3:0]  e_be;
   logic        e_we;
   logic [4:0]  e_rd_addr;
   // literal pins, hand-computed
   logic        lit_rd_en = 1'b0, lit_bus_en = 1'b0;
   logic [31:0] lit_rd, lit_addr, lit_wdata;
   logic [3:0]  lit_be;

   function automatic int m_nbytes(input logic [1:0] size);
      return (size == LSU_SIZE_B) ? 1 : (size == LSU_SIZE_H) ? 2 : 4;
   endfunction

   function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
      return (int'(addr[1:0]) % m_nbytes(size)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
      logic [3:0] be = 4'b0000;
      int o = int'(addr[1:0]);
      for (int k = 0; k < 4; k++)
         if (k >= o && k < o + m_nbytes(size)) be[k] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] m_lanes(input logic [1:0] size, input logic [31:0] wd);
      logic [31:0] r;
      int nb = m_nbytes(size);
      for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % nb) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v = rdata >> (8 * int'(addr[1:0]));
      logic [31:0] mask;
      int nb = m_nbytes(size);
      if (nb < 4) begin
         mask = (32'h1 << (8 * nb)) - 32'h1;
         v = v & mask;
         if (!uns && v[8*nb-1]) v = v | ~mask;
      end
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
         check("data_req", 32'(data_req), 32'(e_req));
         check("done", 32'(done), 32'(e_done));
         check("err", 32'(err), 32'(e_err));
         check("misaligned", 32'(misaligned), 32'(e_mis));
         check("rd_we", 32'(rd_we), 32'(e_rd_we));
         if (e_bus_valid) begin
            check("data_addr", data_addr, e_addr);
            check("data_be", 32'(data_be), 32'(e_be));
            check("data_we", 32'(data_we), 32'(e_we));
            check("data_wdata", data_wdata, e_wdata);
            if (lit_bus_en) begin
               check("lit_addr", data_addr, lit_addr);
               check("lit_be", 32'(data_be), 32'(lit_be));
               check("lit_wdata", data_wdata, lit_wdata);
            end
         end
         if (e_bus_idle) begin
            check("idle_be", 32'(data_be), 32'h0);
            check("idle_we", 32'(data_we), 32'h0);
         end
         if (e_rd_we) begin
            check("rd_addr", 32'(rd_addr), 32'(e_rd_addr));
            check("rd_data", rd_data, e_rd_data);
         end
         if (e_done && lit_rd_en) check("lit_rd_data", rd_data, lit_rd);
         if (e_rd_zero) begin
            check("rst_rd_addr", 32'(rd_addr), 32'h0);
            check("rst_rd_data", rd_data, 32'h0);
            check("rst_data_addr", data_addr, 32'h0);
            check("rst_data_wdata", data_wdata, 32'h0);
         end
      end
   end

   task automatic set_idle();
      e_ready = 1'b1; e_req = 1'b0; e_done = 1'b0; e_err = 1'b0; e_mis = 1'b0;
      e_rd_we = 1'b0; e_bus_valid = 1'b0; e_bus_idle = 1'b1; e_rd_zero = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd);
      cmd_valid = 1'b1; cmd_we = we; cmd_size = size; cmd_unsigned = uns;
      cmd_addr = addr; cmd_wdata = wd; cmd_rd = rd;
      set_idle();
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic req_cycle(input logic we, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wd, input logic gnt);
      set_idle();
      e_ready = 1'b0; e_req = 1'b1; e_bus_idle = 1'b0; e_bus_valid = 1'b1;
      e_addr = {addr[31:2], 2'b00}; e_be = m_be(size, addr); e_we = we;
      e_wdata = m_lanes(size, wd);
      data_gnt = gnt;
      step();
      data_gnt = 1'b0;
   endtask

   task automatic run_cmd(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                          input int gdly, input logic [31:0] rdata, input logic berr);
      present(we, size, uns, addr, wd, rd);
      if (m_mis(size, addr)) begin
         set_idle(); e_mis = 1'b1;
         step();
         set_idle();
         step();
         return;
      end
      for (int i = 0; i <= gdly; i++) req_cycle(we, size, addr, wd, i == gdly);
      set_idle(); e_ready = 1'b0; e_bus_idle = 1'b0;
      data_rvalid = 1'b1; data_rdata = rdata; data_err = berr;
      step();
      data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'h0;
      set_idle();
      e_done = 1'b1; e_err = berr;
      e_rd_we = !berr && !we && (rd != 5'd0);
      e_rd_addr = rd; e_rd_data = m_load(size, uns, addr, rdata);
      step();
      set_idle();
      step();
      lit_rd_en = 1'b0; lit_bus_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_size = LSU_SIZE_W; cmd_unsigned = 1'b0;
      cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_rd = 5'd0;
      data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0; data_err = 1'b0;
      set_idle();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      set_idle(); e_rd_zero = 1'b1; chk_en = 1'b1;
      step();
      set_idle();

      lit_rd_en = 1'b1; lit_rd = 32'hDEADBEEF;
      lit_bus_en = 1'b1; lit_addr = 32'h100; lit_be = 4'b1111; lit_wdata = 32'h0;
      run_cmd(1'b0, LSU_SIZE_W, 1'b0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF, 1'b0);

      lit_rd_en = 1'b1; lit_rd = 32'hFFFFFF80;
      lit_bus_en = 1'b1; lit_addr = 32'h100; lit_be = 4'b1000; lit_wdata = 32'h0;
      run_cmd(1'b0, LSU_SIZE_B, 1'b0, 32'h103, 32'h0, 5'd7, 0, 32'h80FFFFFF, 1'b0);
      lit_rd_en = 1'b1; lit_rd = 32'h00000080;
      run_cmd(1'b0, LSU_SIZE_B, 1'b1, 32'h103, 32'h0, 5'd7, 1, 32'h80FFFFFF, 1'b0);

      lit_bus_en = 1'b1; lit_addr = 32'h200; lit_be = 4'b1100; lit_wdata = 32'hABCDABCD;
      run_cmd(1'b1, LSU_SIZE_H, 1'b0, 32'h202, 32'h1234ABCD, 5'd3, 3, 32'h0, 1'b0);

      run_cmd(1'b0, LSU_SIZE_W, 1'b0, 32'h101, 32'h0, 5'd4, 0, 32'h0, 1'b0);
      run_cmd(1'b0, LSU_SIZE_H, 1'b0, 32'h103, 32'h0, 5'd4, 0, 32'h0, 1'b0);
      run_cmd(1'b1, LSU_SIZE_W, 1'b0, 32'h10A, 32'h55AA55AA, 5'd0, 0, 32'h0, 1'b0);

      run_cmd(1'b0, LSU_SIZE_W, 1'b0, 32'h400, 32'h0, 5'd9, 1, 32'h12345678, 1'b1);
      run_cmd(1'b0, LSU_SIZE_W, 1'b0, 32'h404, 32'h0, 5'd0, 0, 32'h12345678, 1'b0);

      lit_rd_en = 1'b1; lit_rd = 32'hFFFF8001;
      run_cmd(1'b0, LSU_SIZE_H, 1'b0, 32'h502, 32'h0, 5'd12, 0, 32'h80011234, 1'b0);
      lit_rd_en = 1'b1; lit_rd = 32'h00008001;
      run_cmd(1'b0, LSU_SIZE_H, 1'b1, 32'h502, 32'h0, 5'd13, 2, 32'h80011234, 1'b0);
      lit_bus_en = 1'b1; lit_addr = 32'h600; lit_be = 4'b0010; lit_wdata = 32'h5A5A5A5A;
      run_cmd(1'b1, LSU_SIZE_B, 1'b0, 32'h601, 32'hFFFFFF5A, 5'd1, 0, 32'h0, 1'b0);
      lit_rd_en = 1'b1; lit_rd = 32'h0000007F;
      run_cmd(1'b0, LSU_SIZE_B, 1'b0, 32'h601, 32'h0, 5'd31, 0, 32'hAA007F00, 1'b0);
      run_cmd(1'b1, LSU_SIZE_W, 1'b0, 32'h700, 32'hCAFEF00D, 5'd2, 2, 32'h0, 1'b0);

      // reset while waiting for the response; the late rvalid must be ignored
      present(1'b0, LSU_SIZE_W, 1'b0, 32'h300, 32'h0, 5'd9);
      req_cycle(1'b0, LSU_SIZE_W, 32'h300, 32'h0, 1'b1);
      set_idle(); e_ready = 1'b0; e_bus_idle = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_idle(); e_rd_zero = 1'b1;
      data_rvalid = 1'b1; data_rdata = 32'h11111111;
      step();
      data_rvalid = 1'b0; data_rdata = 32'h0;
      set_idle(); e_rd_zero = 1'b1;
      step();
      set_idle();
      run_cmd(1'b0, LSU_SIZE_W, 1'b0, 32'h800, 32'h0, 5'd6, 0, 32'h0BADF00D, 1'b0);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/jedro_1_lsu.md
Name: jedro_1_lsu

Overview:
Load-store unit for the jedro_1 core. It sits directly downstream of the decoder/ALU and drives the core's data memory interface (req/gnt/rvalid handshake).
- Takes one memory command at a time (ALU-computed address, store data, size, signedness).
- Generates byte enables and lane-aligned write data.
- Extracts and sign/zero-extends load data, then returns it to the register file write port.

Parameters:
DATA_WIDTH, 32, data/address width (only 32 supported)
REG_ADDR_WIDTH, 5, destination register address width

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, synchronous, active-high
cmd_valid_i  in  1  command present
cmd_ready_o  out  1  LSU can accept command (IDLE)
cmd_we_i  in  1  1=store, 0=load
cmd_size_i  in  2  LSU_SIZE_B/H/W
cmd_unsigned_i  in  1  load zero-extend (LBU/LHU)
cmd_addr_i  in  DATA_WIDTH  byte address from ALU
cmd_wdata_i  in  DATA_WIDTH  store data (rs2), LSB-aligned
cmd_rd_i  in  REG_ADDR_WIDTH  load destination
rd_we_o  out  1  regfile write strobe
rd_addr_o  out  REG_ADDR_WIDTH  regfile write address
rd_data_o  out  DATA_WIDTH  extended load data
done_o  out  1  one-cycle pulse, transaction completed
err_o  out  1  one-cycle pulse, bus error
misaligned_o  out  1  one-cycle pulse, misaligned command rejected
data_req_o  out  1  bus request
data_gnt_i  in  1  bus grant
data_rvalid_i  in  1  response valid
data_we_o  out  1  bus write enable
data_be_o  out  4  byte enables
data_addr_o  out  DATA_WIDTH  word-aligned address
data_wdata_o  out  DATA_WIDTH  lane-aligned write data
data_rdata_i  in  DATA_WIDTH  read data
data_err_i  in  1  error qualifier, valid with rvalid

Behaviour:
- Reset (rst_i=1 at clock edge):
  - State goes to IDLE.
  - All outputs are 0, except cmd_ready_o=1 once in IDLE.
  - Any outstanding bus transaction is abandoned; rvalid arriving later in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE: cmd_ready_o=1. On cmd_valid_i, the command is checked for alignment.
  - Misaligned: size H with addr[0]=1, or size W with addr[1:0]!=0.
    - Misaligned command: no bus access; misaligned_o=1 next cycle; stay IDLE.
  - Aligned command: register bus fields, then go to REQ. data_req_o=1 from the next cycle (1-cycle latency).
    - data_addr_o = {addr[31:2],2'b00}.
    - data_be_o: B = 4'b0001<<off; H = 4'b0011<<off; W = 4'b1111 (off = addr[1:0]).
    - data_wdata_o = wdata replicated into lanes (B: {4{wdata[7:0]}}, H: {2{wdata[15:0]}}, W: wdata).
    - data_we_o = cmd_we_i.
    - off, size, unsigned and rd are latched internally.
- REQ: data_req_o=1.
  - data_addr_o, data_be_o, data_we_o and data_wdata_o stay stable until data_gnt_i=1.
  - On gnt: data_req_o=0 next cycle, go to WAIT.
  - rvalid in REQ is ignored; the bus guarantees rvalid ≥1 cycle after gnt.
- WAIT: data_req_o=0. On data_rvalid_i, return to IDLE (cmd_ready_o=1 next cycle). Outputs registered, pulsed for one cycle:
  - done_o=1 always.
  - If data_err_i=1: err_o=1 and rd_we_o stays 0.
  - Else if load: rd_we_o=1 unless rd==0, with rd_addr_o=rd.
    - rd_data_o = data_rdata_i >> (8*off), then extended.
    - B: bit7 sign-extend or zero-extend.
    - H: bit15 sign-extend or zero-extend.
    - W: passthrough.
  - Store: rd_we_o=0.
- cmd_valid_i outside IDLE is not accepted; the upstream stage must hold the command.
- Minimum load latency, accept to rd_we_o with gnt on the first REQ cycle and rvalid on the next: 3 cycles.
- Between transactions, rd_data_o/rd_addr_o hold their last values; data_be_o/data_we_o return to 0 in IDLE.

Decomposition:
- Add to the shared defines file:
  - LSU_SIZE_B=2'b00, LSU_SIZE_H=2'b01, LSU_SIZE_W=2'b10.
  - LSU state encodings.
  - DATA_WIDTH and REG_ADDR_WIDTH defaults.
- One sub-module, jedro_1_lsu_load_align: combinational shift plus sign/zero extension. Inputs rdata, off, size, unsigned; output 32-bit result.

Test Plan:
- LW addr=0x100, rd=5, gnt immediate, rvalid next cycle with rdata=0xDEADBEEF:
  - data_addr_o=0x100, be=4'b1111, we=0.
  - rd_we_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF, done_o=1.
- LB addr=0x103, rdata=0x80FFFFFF:
  - be=4'b1000, rd_data_o=0xFFFFFF80.
  - Same access as LBU: rd_data_o=0x00000080.
- SH addr=0x202, wdata=0x1234ABCD, gnt held low 3 cycles:
  - req/addr=0x200/be=4'b1100/wdata=0xABCDABCD stable all 4 cycles.
  - rd_we_o=0, done_o=1 after rvalid.
- LW addr=0x101: misaligned_o=1 next cycle, data_req_o never asserted, cmd_ready_o stays 1.
- LW with rvalid and data_err_i=1: err_o=1, done_o=1, rd_we_o=0.
  - Separately, LW with rd=0: no rd_we_o.
- rst_i asserted in WAIT:
  - Next cycle all outputs 0 and cmd_ready_o=1.
  - A late rvalid produces no done_o/rd_we_o.
